// File: rtl/button_conditioner.sv
// button_conditioner
// Turns N_BTN raw, bouncing, asynchronous push-button levels into a clean
// one-hot command pulse (one clock wide) per accepted press.
//   raw -> 2-flop synchronizer -> per-bit debounce -> rise detect -> FSM
// Optional build macro: AUTO_REPEAT_EN -- while the single latched button
// stays held alone, the code is re-emitted every REPEAT_CYCLES cycles.
//
// state        | meaning
// IDLE         | waiting for a debounced rising edge
// EMIT         | btn_code carries the latched one-hot code for this cycle
// WAIT_RELEASE | press held; wait until every debounced level is low
module button_conditioner #(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_CYCLES   = 50000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_code,
    output logic [N_BTN-1:0] btn_level,
    output logic             busy
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] IDLE         = 2'd0;
    localparam logic [1:0] EMIT         = 2'd1;
    localparam logic [1:0] WAIT_RELEASE = 2'd2;

    logic [N_BTN-1:0] sync_a;
    logic [N_BTN-1:0] sync_b;
    logic [CNT_W-1:0] db_cnt [N_BTN];
    logic [N_BTN-1:0] level_d;
    logic [N_BTN-1:0] rise;
    logic [N_BTN-1:0] rise_low;
    logic [N_BTN-1:0] latched;
    logic [1:0]       state;

`ifdef AUTO_REPEAT_EN
    localparam int RPT_W = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);
    logic [RPT_W-1:0] rpt_cnt;
`endif

    // Two-flop synchronizer, nothing between the stages.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= btn_raw;
            sync_b <= sync_a;
        end
    end

    // Per-bit debounce: a level change is accepted after DEBOUNCE_CYCLES
    // consecutive mismatching edges; any agreement restarts the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_level <= '0;
            for (int i = 0; i < N_BTN; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                if (sync_b[i] == btn_level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    btn_level[i] <= sync_b[i];
                    db_cnt[i]    <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Delayed level for rising-edge detection.
    always_ff @(posedge clk) begin
        if (reset) level_d <= '0;
        else       level_d <= btn_level;
    end

    // Lowest-index rising bit wins when several rise together.
    always_comb begin
        rise     = btn_level & ~level_d;
        rise_low = rise & (~rise + N_BTN'(1));
    end

    assign busy = (state == WAIT_RELEASE);

    // Press sequencer; btn_code is registered and only nonzero in EMIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            latched  <= '0;
            btn_code <= '0;
`ifdef AUTO_REPEAT_EN
            rpt_cnt  <= '0;
`endif
        end else begin
            btn_code <= '0;
            case (state)
                IDLE: begin
                    if (|rise) begin
                        latched  <= rise_low;
                        btn_code <= rise_low;
                        state    <= EMIT;
                    end
                end
                EMIT: begin
                    state <= WAIT_RELEASE;
`ifdef AUTO_REPEAT_EN
                    rpt_cnt <= '0;
`endif
                end
                WAIT_RELEASE: begin
                    if (btn_level == '0) begin
                        state <= IDLE;
                    end
`ifdef AUTO_REPEAT_EN
                    // Repeat only while the latched button is held alone;
                    // any extra button freezes and clears the period.
                    else if (btn_level == latched) begin
                        if (rpt_cnt == RPT_LAST) begin
                            rpt_cnt  <= '0;
                            btn_code <= latched;
                            state    <= EMIT;
                        end else begin
                            rpt_cnt <= rpt_cnt + 1'b1;
                        end
                    end else begin
                        rpt_cnt <= '0;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
